board_dump_tx: RTL

- Reader-side counterpart to the board update pipeline: snapshots the board as it streams out in raster order, one row per frame.
- Input is the alive/hcount/vcount stream at the cell-update pipeline output.
- Packs each row into bytes and emits them on a valid/ready byte interface. A serial-TX block later turns this into a host-side board export.
- Asserts hold_out while dumping so the top level suppresses generation updates and the snapshot stays coherent across frames.

---
 rtl/board_dump_tx_pkg.sv | 33 +++
 rtl/board_dump_tx_row_packer.sv | 47 ++++
 rtl/board_dump_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/board_dump_tx_pkg.sv
// Shared types for the board dump reader.
// Raster coordinate widths, dump FSM encoding and stream constants.
package board_dump_tx_pkg;

  localparam int BOARD_SIZE     = 64;
  localparam int LOG_BOARD_SIZE = 6;
  localparam int HCOUNT_WIDTH   = 11;
  localparam int VCOUNT_WIDTH   = 10;

  typedef logic [HCOUNT_WIDTH-1:0] hcount_t;
  typedef logic [VCOUNT_WIDTH-1:0] vcount_t;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WAIT_ROW,
    CAPTURE,
    SEND,
    DONE
  } dump_state_t;

  localparam logic [7:0] DUMP_HEADER = 8'hA5;
  localparam int DUMP_BYTES_PER_ROW  = BOARD_SIZE / 8;

  function automatic int idx_bits(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  function automatic int pos_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_dump_tx_row_packer.sv
// One-row snapshot buffer: single-bit writes by x position,
// byte reads by byte index with bit 0 holding the lowest x.
module row_packer
  import board_dump_tx_pkg::*;
#(
  parameter int BOARD_W = 16,
  parameter int IDX_W   = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        wr_en_in,
  input  logic [pos_bits(BOARD_W)-1:0] wr_idx_in,
  input  logic                        wr_bit_in,
  input  logic [IDX_W-1:0]            rd_idx_in,
  output logic [7:0]                  rd_byte_out
);

  localparam int NBYTES = BOARD_W / 8;

  logic [BOARD_W-1:0] rowbuf_q;
  logic [BOARD_W-1:0] rowbuf_d;

  always_comb begin
    rowbuf_d = rowbuf_q;
    if (wr_en_in) begin
      rowbuf_d[wr_idx_in] = wr_bit_in;
    end
  end

  always_comb begin
    rd_byte_out = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (rd_idx_in == IDX_W'(k)) begin
        rd_byte_out = rowbuf_q[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rowbuf_q <= '0;
    end else begin
      rowbuf_q <= rowbuf_d;
    end
  end

endmodule

// File: rtl/board_dump_tx.sv
// Board snapshot dumper: captures one raster row per pass and streams it
// as bytes behind a header, holding evolution frozen while busy.
module board_dump_tx
  import board_dump_tx_pkg::*;
#(
  parameter int         BOARD_W     = BOARD_SIZE,
  parameter logic [7:0] HEADER_BYTE = DUMP_HEADER
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  input  logic                    alive_in,
  input  logic                    byte_ready_in,
  output logic [7:0]              byte_out,
  output logic                    byte_valid_out,
  output logic                    busy_out,
  output logic                    hold_out,
  output logic                    done_out
);

  localparam int NBYTES = BOARD_W / 8;
  localparam int IDX_W  = idx_bits(NBYTES);
  localparam int ROW_W  = pos_bits(BOARD_W);

  dump_state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic xfer;
  logic row_hit;
  logic on_board;
  logic wr_en;
  logic [7:0] pk_byte;

  row_packer #(
    .BOARD_W (BOARD_W),
    .IDX_W   (IDX_W)
  ) u_packer (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .wr_en_in    (wr_en),
    .wr_idx_in   (hcount_in[ROW_W-1:0]),
    .wr_bit_in   (alive_in),
    .rd_idx_in   (idx_q),
    .rd_byte_out (pk_byte)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    wr_en    = 1'b0;
    xfer     = valid_q && byte_ready_in;
    row_hit  = (vcount_in == vcount_t'(row_q));
    on_board = (hcount_in < hcount_t'(BOARD_W));
    unique case (state_q)
      IDLE: begin
        if (start_in) state_d = HEADER;
      end
      HEADER: begin
        if (xfer) begin
          state_d = WAIT_ROW;
          row_d   = '0;
        end
      end
      // Only a column-0 hit starts a capture, so the row is never partial.
      WAIT_ROW: begin
        if (row_hit && hcount_in == '0) begin
          wr_en   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (row_hit && on_board) begin
          wr_en = 1'b1;
          if (hcount_in == hcount_t'(BOARD_W - 1)) begin
            state_d = SEND;
            idx_d   = '0;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q != IDX_W'(NBYTES - 1)) begin
            idx_d = idx_q + 1'b1;
          end else if (row_q == ROW_W'(BOARD_W - 1)) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = WAIT_ROW;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == HEADER) || (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Byte mux only looks at flops, so it is steady across a stall.
  always_comb begin
    byte_out = 8'h00;
    if (state_q == HEADER) begin
      byte_out = HEADER_BYTE;
    end else if (state_q == SEND) begin
      byte_out = pk_byte;
    end
  end

  assign byte_valid_out = valid_q;
  assign busy_out       = busy_q;
  assign hold_out       = busy_q;
  assign done_out       = done_q;

endmodule
